// File: rtl/issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl_pkg
// Description : Shared widths, stall/issue encodings, MIPS opcode/funct
//               constants and the per-slot decode record used by the
//               dual-issue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_ctrl_pkg;

  // Bus widths
  localparam int STALLBUS_WD = 6;
  localparam int IB_TO_ID_WD = 130;
  localparam int HILO_CNT_WD = $clog2(33 + 1);

  // Stall bus encoding (per stage bit)
  localparam logic NoStop = 1'b0;
  localparam logic Stop   = 1'b1;

  // Issue mode encoding
  localparam logic SingleIssue = 1'b0;
  localparam logic DualIssue   = 1'b1;

  // Primary opcodes
  localparam logic [5:0] c_OP_SPECIAL = 6'h00;
  localparam logic [5:0] c_OP_REGIMM  = 6'h01;
  localparam logic [5:0] c_OP_J       = 6'h02;
  localparam logic [5:0] c_OP_JAL     = 6'h03;
  localparam logic [5:0] c_OP_BEQ     = 6'h04;
  localparam logic [5:0] c_OP_BNE     = 6'h05;
  localparam logic [5:0] c_OP_BLEZ    = 6'h06;
  localparam logic [5:0] c_OP_BGTZ    = 6'h07;
  localparam logic [5:0] c_OP_LUI     = 6'h0f;
  localparam logic [5:0] c_OP_COP0    = 6'h10;
  localparam logic [5:0] c_OP_LB      = 6'h20;
  localparam logic [5:0] c_OP_LH      = 6'h21;
  localparam logic [5:0] c_OP_LW      = 6'h23;
  localparam logic [5:0] c_OP_LBU     = 6'h24;
  localparam logic [5:0] c_OP_LHU     = 6'h25;
  localparam logic [5:0] c_OP_SB      = 6'h28;
  localparam logic [5:0] c_OP_SH      = 6'h29;
  localparam logic [5:0] c_OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] c_FN_SLL     = 6'h00;
  localparam logic [5:0] c_FN_SRL     = 6'h02;
  localparam logic [5:0] c_FN_SRA     = 6'h03;
  localparam logic [5:0] c_FN_SLLV    = 6'h04;
  localparam logic [5:0] c_FN_SRLV    = 6'h06;
  localparam logic [5:0] c_FN_SRAV    = 6'h07;
  localparam logic [5:0] c_FN_JR      = 6'h08;
  localparam logic [5:0] c_FN_JALR    = 6'h09;
  localparam logic [5:0] c_FN_SYSCALL = 6'h0c;
  localparam logic [5:0] c_FN_BREAK   = 6'h0d;
  localparam logic [5:0] c_FN_MFHI    = 6'h10;
  localparam logic [5:0] c_FN_MTHI    = 6'h11;
  localparam logic [5:0] c_FN_MFLO    = 6'h12;
  localparam logic [5:0] c_FN_MTLO    = 6'h13;
  localparam logic [5:0] c_FN_MULT    = 6'h18;
  localparam logic [5:0] c_FN_MULTU   = 6'h19;
  localparam logic [5:0] c_FN_DIV     = 6'h1a;
  localparam logic [5:0] c_FN_DIVU    = 6'h1b;
  localparam logic [5:0] c_FN_SLT     = 6'h2a;
  localparam logic [5:0] c_FN_SLTU    = 6'h2b;

  // COP0 rs-field sub-ops
  localparam logic [4:0] c_CP0_MF = 5'b00000;
  localparam logic [4:0] c_CP0_MT = 5'b00100;

  // Per-slot decode summary; dest==0 means "writes nothing"
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rs_rd;
    logic       rt_rd;
    logic       is_mem;
    logic       is_load;
    logic       is_br;
    logic       is_hilo;
    logic       is_mul;
    logic       is_div;
    logic       is_priv;
  } dec_t;

  // True when the decoded instruction reads architectural register r (r!=0)
  function automatic logic reads_reg(input dec_t d, input logic [4:0] r);
    return (r != 5'd0) && ((d.rs_rd && (d.rs == r)) || (d.rt_rd && (d.rt == r)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_decode.sv
`default_nettype none
// ============================================================================
// Module      : issue_decode
// Description : Combinational class decode of one instruction word for the
//               issue scheduler: source read flags, destination register and
//               class flags (mem / branch / HI-LO / privileged).
// Ports       : inst_i - 32-bit instruction word
//               dec_o  - decode record (see issue_ctrl_pkg::dec_t)
// Revision    : 1.0 - initial release
// ============================================================================
module issue_decode
  import issue_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_unused_shamt;

  assign w_op           = inst_i[31:26];
  assign w_rs           = inst_i[25:21];
  assign w_rt           = inst_i[20:16];
  assign w_rd           = inst_i[15:11];
  assign w_fn           = inst_i[5:0];
  assign w_unused_shamt = ^inst_i[10:6];

  always_comb begin
    dec_o    = '0;
    dec_o.rs = w_rs;
    dec_o.rt = w_rt;
    case (w_op)
      c_OP_SPECIAL: begin
        case (w_fn)
          c_FN_SLL, c_FN_SRL, c_FN_SRA: begin
            dec_o.rt_rd = 1'b1;
            dec_o.dest  = w_rd;
          end
          c_FN_SLLV, c_FN_SRLV, c_FN_SRAV: begin
            dec_o.rs_rd = 1'b1;
            dec_o.rt_rd = 1'b1;
            dec_o.dest  = w_rd;
          end
          c_FN_JR: begin
            dec_o.rs_rd = 1'b1;
            dec_o.is_br = 1'b1;
          end
          c_FN_JALR: begin
            dec_o.rs_rd = 1'b1;
            dec_o.is_br = 1'b1;
            dec_o.dest  = w_rd;
          end
          c_FN_SYSCALL, c_FN_BREAK: dec_o.is_priv = 1'b1;
          c_FN_MFHI, c_FN_MFLO: begin
            dec_o.dest    = w_rd;
            dec_o.is_hilo = 1'b1;
          end
          c_FN_MTHI, c_FN_MTLO: begin
            dec_o.rs_rd   = 1'b1;
            dec_o.is_hilo = 1'b1;
          end
          c_FN_MULT, c_FN_MULTU: begin
            dec_o.rs_rd   = 1'b1;
            dec_o.rt_rd   = 1'b1;
            dec_o.is_hilo = 1'b1;
            dec_o.is_mul  = 1'b1;
          end
          c_FN_DIV, c_FN_DIVU: begin
            dec_o.rs_rd   = 1'b1;
            dec_o.rt_rd   = 1'b1;
            dec_o.is_hilo = 1'b1;
            dec_o.is_div  = 1'b1;
          end
          default: begin
            // add/addu/sub/subu/and/or/xor/nor (0x20-0x27) and slt/sltu
            if ((w_fn[5:3] == 3'b100) || (w_fn == c_FN_SLT) || (w_fn == c_FN_SLTU)) begin
              dec_o.rs_rd = 1'b1;
              dec_o.rt_rd = 1'b1;
              dec_o.dest  = w_rd;
            end
          end
        endcase
      end
      c_OP_REGIMM: begin
        dec_o.rs_rd = 1'b1;
        dec_o.is_br = 1'b1;
        // bltzal/bgezal have rt[4] set and link into $31
        if (w_rt[4]) dec_o.dest = 5'd31;
      end
      c_OP_J: dec_o.is_br = 1'b1;
      c_OP_JAL: begin
        dec_o.is_br = 1'b1;
        dec_o.dest  = 5'd31;
      end
      c_OP_BEQ, c_OP_BNE: begin
        dec_o.rs_rd = 1'b1;
        dec_o.rt_rd = 1'b1;
        dec_o.is_br = 1'b1;
      end
      c_OP_BLEZ, c_OP_BGTZ: begin
        dec_o.rs_rd = 1'b1;
        dec_o.is_br = 1'b1;
      end
      c_OP_LUI: dec_o.dest = w_rt;
      c_OP_COP0: begin
        dec_o.is_priv = 1'b1;
        if (w_rs == c_CP0_MF) dec_o.dest  = w_rt;
        if (w_rs == c_CP0_MT) dec_o.rt_rd = 1'b1;
      end
      c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU: begin
        dec_o.rs_rd   = 1'b1;
        dec_o.dest    = w_rt;
        dec_o.is_mem  = 1'b1;
        dec_o.is_load = 1'b1;
      end
      c_OP_SB, c_OP_SH, c_OP_SW: begin
        dec_o.rs_rd  = 1'b1;
        dec_o.rt_rd  = 1'b1;
        dec_o.is_mem = 1'b1;
      end
      default: begin
        // addi..xori (0x08-0x0e): rs source, rt destination
        if (w_op[5:3] == 3'b001) begin
          dec_o.rs_rd = 1'b1;
          dec_o.dest  = w_rt;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl
// Description : Dual-issue scheduler between the instruction buffer and the
//               two decode slots. Chooses none/single/dual issue, drives the
//               buffer pop controls, masks slot-2 valid and requests a stall
//               for load-use and HI/LO-busy hazards.
// Ports       : clk, rst (async, active-low), flush
//               stall              - stall bus, bit 2 = decode stage
//               ib_to_id_bus       - {v2, pc2, inst2, v1, pc1, inst1}
//               issue_o            - pop request to the buffer
//               issue_mode_o       - SingleIssue / DualIssue
//               id_valid_o         - {slot2, slot1} valids to ID
//               stallreq_for_issue - hazard stall request
// Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [STALLBUS_WD-1:0] stall,
  input  logic [IB_TO_ID_WD-1:0] ib_to_id_bus,
  output logic                   issue_o,
  output logic                   issue_mode_o,
  output logic [1:0]             id_valid_o,
  output logic                   stallreq_for_issue
);

  localparam int c_CNT_WD = $clog2(DIV_CYCLES + 1);

  // Registered state
  logic                ld_vld_q,   ld_vld_d;
  logic [4:0]          ld_dest_q,  ld_dest_d;
  logic [c_CNT_WD-1:0] hilo_cnt_q, hilo_cnt_d;

  // Decode
  dec_t w_dec1;
  dec_t w_dec2;

  issue_decode u_dec1 (.inst_i(ib_to_id_bus[31:0]),  .dec_o(w_dec1));
  issue_decode u_dec2 (.inst_i(ib_to_id_bus[96:65]), .dec_o(w_dec2));

  logic w_stop;
  logic w_v1, w_v2;
  logic w_hilo_busy;
  logic w_blk1, w_blk2;
  logic w_pair_ok;
  logic w_issue, w_dual;
  logic w_set_div, w_set_mul;
  logic w_unused;

  // PCs and the other stall bits are only carried for other consumers
  assign w_unused = ^{ib_to_id_bus[63:32], ib_to_id_bus[128:97],
                      stall[STALLBUS_WD-1:3], stall[1:0]};

  assign w_stop = (stall[2] == Stop);
  // Flush forces every output low, so it simply kills both slot valids
  assign w_v1   = ib_to_id_bus[64]  & ~w_stop & ~flush;
  assign w_v2   = ib_to_id_bus[129] & ~w_stop & ~flush;

  assign w_hilo_busy = (hilo_cnt_q != '0);

  assign w_blk1 = (ld_vld_q & reads_reg(w_dec1, ld_dest_q)) | (w_hilo_busy & w_dec1.is_hilo);
  assign w_blk2 = (ld_vld_q & reads_reg(w_dec2, ld_dest_q)) | (w_hilo_busy & w_dec2.is_hilo);

  // A branch in slot 2 is held back so it travels with its delay slot;
  // a branch in slot 1 is free to pair with the delay slot behind it.
  assign w_pair_ok = ~w_blk2
                   & ~reads_reg(w_dec2, w_dec1.dest)
                   & ~((w_dec1.dest != 5'd0) && (w_dec1.dest == w_dec2.dest))
                   & ~(w_dec1.is_mem  & w_dec2.is_mem)
                   & ~(w_dec1.is_hilo & w_dec2.is_hilo)
                   & ~(w_dec1.is_priv | w_dec2.is_priv)
                   & ~w_dec2.is_br;

  assign w_issue = w_v1 & ~w_blk1;
  assign w_dual  = w_issue & w_v2 & w_pair_ok;

  assign issue_o            = w_issue;
  assign issue_mode_o       = w_dual ? DualIssue : SingleIssue;
  assign id_valid_o         = {w_dual, w_issue};
  assign stallreq_for_issue = w_v1 & w_blk1;

  // Both slots can never carry HI/LO ops together, so at most one of these fires
  assign w_set_div = (w_issue & w_dec1.is_div) | (w_dual & w_dec2.is_div);
  assign w_set_mul = (w_issue & w_dec1.is_mul) | (w_dual & w_dec2.is_mul);

  // Load-use scoreboard: remembers the youngest load issued in the last
  // advancing cycle; any advancing cycle without a load ages it out.
  always_comb begin
    ld_vld_d  = ld_vld_q;
    ld_dest_d = ld_dest_q;
    if (flush) begin
      ld_vld_d  = 1'b0;
      ld_dest_d = 5'd0;
    end else if (!w_stop) begin
      if (w_dual && w_dec2.is_load) begin
        ld_vld_d  = 1'b1;
        ld_dest_d = w_dec2.dest;
      end else if (w_issue && w_dec1.is_load) begin
        ld_vld_d  = 1'b1;
        ld_dest_d = w_dec1.dest;
      end else begin
        ld_vld_d  = 1'b0;
        ld_dest_d = 5'd0;
      end
    end
  end

  // HI/LO busy counter tracks real time of the multiplier/divider, so it
  // keeps counting through decode stalls.
  always_comb begin
    hilo_cnt_d = hilo_cnt_q;
    if (flush) begin
      hilo_cnt_d = '0;
    end else if (w_set_div) begin
      hilo_cnt_d = c_CNT_WD'(DIV_CYCLES);
    end else if (w_set_mul) begin
      hilo_cnt_d = c_CNT_WD'(MUL_CYCLES);
    end else if (w_hilo_busy) begin
      hilo_cnt_d = hilo_cnt_q - c_CNT_WD'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_vld_q   <= 1'b0;
      ld_dest_q  <= 5'd0;
      hilo_cnt_q <= '0;
    end else begin
      ld_vld_q   <= ld_vld_d;
      ld_dest_q  <= ld_dest_d;
      hilo_cnt_q <= hilo_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_issue_ctrl
// Description : Self-checking bench for issue_ctrl. A driver presents the
//               head of a modelled instruction buffer each cycle, predicts
//               the issue decision from instruction classes and hazard
//               timing, and queues it; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int MULC = 2;
  localparam int DIVC = 33;
  localparam int C_MEM = 1, C_BR = 2, C_HILO = 4, C_PRIV = 8, C_LOAD = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [STALLBUS_WD-1:0] stall;
  logic [IB_TO_ID_WD-1:0] bus;
  logic                   issue_o;
  logic                   issue_mode_o;
  logic [1:0]             id_valid_o;
  logic                   stallreq;

  always #5 clk = ~clk;

  issue_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .ib_to_id_bus(bus),
    .issue_o(issue_o), .issue_mode_o(issue_mode_o), .id_valid_o(id_valid_o),
    .stallreq_for_issue(stallreq)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] reads;
    int          dest;
    bit          mem, br, hilo, priv, load;
    int          md;     // 0 none, 1 multiply, 2 divide
  } item_t;

  typedef struct packed {
    int         cyc;
    logic       issue;
    logic       mode;
    logic [1:0] idv;
    logic       sreq;
  } exp_t;

  item_t prog[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    sreq_seen = 0;

  // Reference-model state expressed as event times
  int cyc        = 0;     // every clock cycle
  int ns_idx     = 0;     // advancing (non-stopped) cycles
  int ld_idx     = -100;  // advancing cycle in which the last load issued
  int ld_reg     = 0;
  int hilo_until = -1;    // last cycle in which HI/LO is still busy

  function automatic logic [31:0] bit_of(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

  function automatic item_t mk(input logic [31:0] w, input logic [31:0] rm,
                               input int dest, input int cls, input int md);
    item_t it;
    it.word = w; it.reads = rm; it.dest = dest; it.md = md;
    it.mem  = (cls & C_MEM)  != 0;
    it.br   = (cls & C_BR)   != 0;
    it.hilo = (cls & C_HILO) != 0;
    it.priv = (cls & C_PRIV) != 0;
    it.load = (cls & C_LOAD) != 0;
    return it;
  endfunction

  function automatic item_t i_addu(input logic [4:0] rd, rs, rt);
    return mk({6'h00, rs, rt, rd, 5'h00, 6'h21}, bit_of(rs) | bit_of(rt), int'(rd), 0, 0);
  endfunction
  function automatic item_t i_ori(input logic [4:0] rt, rs, input logic [15:0] imm);
    return mk({6'h0d, rs, rt, imm}, bit_of(rs), int'(rt), 0, 0);
  endfunction
  function automatic item_t i_lui(input logic [4:0] rt);
    return mk({6'h0f, 5'h00, rt, 16'h1234}, 32'd0, int'(rt), 0, 0);
  endfunction
  function automatic item_t i_sll(input logic [4:0] rd, rt, sa);
    return mk({6'h00, 5'h00, rt, rd, sa, 6'h00}, bit_of(rt), int'(rd), 0, 0);
  endfunction
  function automatic item_t i_lw(input logic [4:0] rt, rs, input logic [15:0] off);
    return mk({6'h23, rs, rt, off}, bit_of(rs), int'(rt), C_MEM | C_LOAD, 0);
  endfunction
  function automatic item_t i_sw(input logic [4:0] rt, rs, input logic [15:0] off);
    return mk({6'h2b, rs, rt, off}, bit_of(rs) | bit_of(rt), 0, C_MEM, 0);
  endfunction
  function automatic item_t i_mult(input logic [4:0] rs, rt);
    return mk({6'h00, rs, rt, 10'h000, 6'h18}, bit_of(rs) | bit_of(rt), 0, C_HILO, 1);
  endfunction
  function automatic item_t i_div(input logic [4:0] rs, rt);
    return mk({6'h00, rs, rt, 10'h000, 6'h1a}, bit_of(rs) | bit_of(rt), 0, C_HILO, 2);
  endfunction
  function automatic item_t i_mflo(input logic [4:0] rd);
    return mk({16'h0000, rd, 5'h00, 6'h12}, 32'd0, int'(rd), C_HILO, 0);
  endfunction
  function automatic item_t i_mthi(input logic [4:0] rs);
    return mk({6'h00, rs, 15'h0000, 6'h11}, bit_of(rs), 0, C_HILO, 0);
  endfunction
  function automatic item_t i_beq(input logic [4:0] rs, rt, input logic [15:0] off);
    return mk({6'h04, rs, rt, off}, bit_of(rs) | bit_of(rt), 0, C_BR, 0);
  endfunction
  function automatic item_t i_jal();
    return mk({6'h03, 26'h0000040}, 32'd0, 31, C_BR, 0);
  endfunction
  function automatic item_t i_mfc0(input logic [4:0] rt, rd);
    return mk({6'h10, 5'h00, rt, rd, 11'h000}, 32'd0, int'(rt), C_PRIV, 0);
  endfunction
  function automatic item_t i_syscall();
    return mk({6'h00, 20'h00000, 6'h0c}, 32'd0, 0, C_PRIV, 0);
  endfunction

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic item_t rand_item();
    int k;
    k = $urandom_range(0, 29);
    if (k < 7)       return i_addu(rr(), rr(), rr());
    else if (k < 10) return i_ori(rr(), rr(), 16'($urandom));
    else if (k < 11) return i_lui(rr());
    else if (k < 12) return i_sll(rr(), rr(), 5'($urandom));
    else if (k < 16) return i_lw(rr(), rr(), 16'($urandom));
    else if (k < 18) return i_sw(rr(), rr(), 16'($urandom));
    else if (k < 20) return i_mult(rr(), rr());
    else if (k < 21) return i_div(rr(), rr());
    else if (k < 23) return i_mflo(rr());
    else if (k < 24) return i_mthi(rr());
    else if (k < 26) return i_beq(rr(), rr(), 16'($urandom));
    else if (k < 27) return i_jal();
    else if (k < 28) return i_mfc0(rr(), rr());
    else if (k < 29) return i_syscall();
    else             return i_addu(5'd0, rr(), rr());
  endfunction

  // Hazard rules in time terms: a load is visible exactly one advancing
  // cycle later; HI/LO is busy through cycle issue+N.
  function automatic bit blocked(input item_t it);
    return ((ld_reg != 0) && (ns_idx == ld_idx + 1) && it.reads[ld_reg]) ||
           ((cyc <= hilo_until) && it.hilo);
  endfunction

  function automatic bit pair_ok(input item_t a, input item_t b);
    return !blocked(b) &&
           !((a.dest != 0) && b.reads[a.dest]) &&
           !((a.dest != 0) && (a.dest == b.dest)) &&
           !(a.mem && b.mem) && !(a.hilo && b.hilo) &&
           !(a.priv || b.priv) && !b.br;
  endfunction

  task automatic push_exp(input bit iss, input bit dual, input bit sreq);
    exp_t e;
    e.cyc = cyc; e.issue = iss; e.mode = dual ? DualIssue : SingleIssue;
    e.idv = {dual, iss}; e.sreq = sreq;
    exp_q.push_back(e);
  endtask

  task automatic model_clear();
    ld_idx = -100; ld_reg = 0; hilo_until = -1;
  endtask

  task automatic drive(input int avail, input bit stop, input bit fl);
    item_t a, b;
    bit    v1, v2, iss, dual, sreq;
    @(posedge clk); #1;
    if (avail > prog.size()) avail = prog.size();
    bus = '0;
    if (avail >= 1) begin
      a = prog[0];
      bus[31:0] = a.word; bus[63:32] = 32'h0000_1000 + 32'(cyc * 8); bus[64] = 1'b1;
    end
    if (avail >= 2) begin
      b = prog[1];
      bus[96:65] = b.word; bus[128:97] = 32'h0000_1004 + 32'(cyc * 8); bus[129] = 1'b1;
    end
    stall = stop ? STALLBUS_WD'(7) : '0;
    flush = fl;
    v1   = (avail >= 1) && !stop && !fl;
    v2   = (avail >= 2) && !stop && !fl;
    iss  = v1 && !blocked(a);
    dual = iss && v2 && pair_ok(a, b);
    sreq = v1 && blocked(a);
    push_exp(iss, dual, sreq);
    if (fl) model_clear();
    else begin
      if (iss && a.md != 0)  hilo_until = cyc + ((a.md == 2) ? DIVC : MULC);
      if (dual && b.md != 0) hilo_until = cyc + ((b.md == 2) ? DIVC : MULC);
      if (!stop) begin
        if (dual && b.load)     begin ld_reg = b.dest; ld_idx = ns_idx; end
        else if (iss && a.load) begin ld_reg = a.dest; ld_idx = ns_idx; end
      end
    end
    if (!stop) ns_idx++;
    if (iss)  void'(prog.pop_front());
    if (dual) void'(prog.pop_front());
    cyc++;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus = '0; stall = '0; flush = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0);
    ns_idx++; cyc++;
  endtask

  // Reset pulse that never overlaps a clock edge: only an asynchronous
  // reset can clear the state before the next cycle's decision.
  task automatic pulse_reset();
    @(posedge clk); #1;
    bus = '0; stall = '0; flush = 1'b0;
    rst = 1'b0; #2; rst = 1'b1;
    model_clear();
    push_exp(1'b0, 1'b0, 1'b0);
    ns_idx++; cyc++;
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && prog.size() > 0; n++) drive(2, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_seen();
    settle();
    sreq_seen = 0;
  endtask

  task automatic check_seen(input string name, input int want);
    settle();
    total++;
    if (sreq_seen != want) begin
      bad++;
      $display("FAIL %s stall cycles got=%0d want=%0d", name, sreq_seen, want);
    end
  endtask

  // Monitor: compares every cycle's outputs against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (stallreq) sreq_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({issue_o, issue_mode_o, id_valid_o, stallreq} !== {e.issue, e.mode, e.idv, e.sreq}) begin
          bad++;
          $display("FAIL outputs cyc=%0d got issue=%b mode=%b idv=%b sreq=%b want issue=%b mode=%b idv=%b sreq=%b",
                   e.cyc, issue_o, issue_mode_o, id_valid_o, stallreq, e.issue, e.mode, e.idv, e.sreq);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0; bus = '0;
    repeat (3) idle_cycle();
    rst = 1'b1;
    idle_cycle();

    // Independent pair -> dual
    prog.push_back(i_addu(5'd3, 5'd1, 5'd2));
    prog.push_back(i_ori(5'd8, 5'd0, 16'd1));
    drain(4);

    // Intra-pair RAW -> single, dependent follows from slot 1
    prog.push_back(i_addu(5'd3, 5'd1, 5'd2));
    prog.push_back(i_addu(5'd4, 5'd3, 5'd1));
    drain(4);

    // Load-use: exactly one stall cycle
    prog.push_back(i_lw(5'd5, 5'd1, 16'd0));
    drive(1, 1'b0, 1'b0);
    prog.push_back(i_addu(5'd6, 5'd5, 5'd0));
    clear_seen();
    drain(4);
    check_seen("load_use", 1);

    // HI/LO busy after div
    prog.push_back(i_div(5'd1, 5'd2));
    drive(1, 1'b0, 1'b0);
    prog.push_back(i_mflo(5'd7));
    clear_seen();
    drain(60);
    check_seen("div_busy", DIVC);

    // Structural mem pair, then branch in slot 2 followed by branch+delay dual
    prog.push_back(i_lw(5'd5, 5'd1, 16'd0));
    prog.push_back(i_sw(5'd2, 5'd1, 16'd4));
    prog.push_back(i_addu(5'd3, 5'd1, 5'd2));
    prog.push_back(i_beq(5'd1, 5'd2, 16'd4));
    prog.push_back(i_ori(5'd8, 5'd0, 16'd1));
    drain(10);

    // Flush with the counter at 20 -> mflo goes immediately
    prog.push_back(i_div(5'd1, 5'd2));
    drive(1, 1'b0, 1'b0);
    repeat (13) drive(0, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1);
    prog.push_back(i_mflo(5'd7));
    clear_seen();
    drain(4);
    check_seen("flush_hilo", 0);

    // Stop with valid heads: no pop, scoreboard held across the stop
    prog.push_back(i_lw(5'd5, 5'd1, 16'd0));
    drive(1, 1'b0, 1'b0);
    prog.push_back(i_addu(5'd6, 5'd5, 5'd0));
    prog.push_back(i_ori(5'd8, 5'd0, 16'd1));
    repeat (3) drive(2, 1'b1, 1'b0);
    clear_seen();
    drain(4);
    check_seen("stop_hold", 1);

    // Asynchronous reset mid-divide
    prog.push_back(i_div(5'd1, 5'd2));
    drive(1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);
    pulse_reset();
    prog.push_back(i_mflo(5'd7));
    clear_seen();
    drain(4);
    check_seen("async_rst", 0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int r;
      while (prog.size() < 6) prog.push_back(rand_item());
      r = $urandom_range(0, 9);
      drive((r < 1) ? 0 : (r < 3) ? 1 : 2,
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 39) == 0));
    end

    settle();
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
